// File: rtl/bit_permute_pipe.sv
// rtl/bit_permute_pipe.sv - bit permutation (pass/reverse/pair-swap/rotate) carried through a valid/ready pipeline
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake
//   in_data, in_mode, in_rot word, permutation select, rotate amount (mode 3)
//   out_valid/out_ready      downstream handshake
//   out_data, out_mode       permuted word and the mode that produced it
//   xfer_count               output transfer counter (only with BIT_PERMUTE_PIPE_COUNT_EN)
//
// Optional feature macro: BIT_PERMUTE_PIPE_COUNT_EN

module bit_permute_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [1:0]               in_mode,
    input  logic [$clog2(WIDTH)-1:0] in_rot,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [1:0]               out_mode
`ifdef BIT_PERMUTE_PIPE_COUNT_EN
    ,
    output logic [31:0]              xfer_count
`endif
);

    localparam int RW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] f_permute(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input logic [RW-1:0]    rot
    );
        logic [WIDTH-1:0]   res;
        logic [2*WIDTH-1:0] dbl;
        int                 sh;
        res = d;
        dbl = '0;
        sh  = 0;
        case (m)
            2'd0: res = d;
            2'd1: begin
                for (int i = 0; i < WIDTH; i++) begin
                    res[i] = d[WIDTH-1-i];
                end
            end
            2'd2: begin
                // An odd MSB has no partner and keeps the default copy.
                for (int i = 0; i + 1 < WIDTH; i += 2) begin
                    res[i]   = d[i+1];
                    res[i+1] = d[i];
                end
            end
            default: begin
                // Rotate-left: shift a doubled copy and keep the upper half.
                sh  = int'(rot) % WIDTH;
                dbl = {d, d} << sh;
                res = dbl[2*WIDTH-1:WIDTH];
            end
        endcase
        return res;
    endfunction

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][WIDTH-1:0] r_data;
    logic [DEPTH-1:0][1:0]       r_mode;

    logic [WIDTH-1:0]            w_perm;
    logic [DEPTH-1:0]            w_space;
    logic [DEPTH-1:0]            w_src_valid;
    logic [DEPTH-1:0][WIDTH-1:0] w_src_data;
    logic [DEPTH-1:0][1:0]       w_src_mode;

    assign w_perm = f_permute(in_data, in_mode, in_rot);

    // Stage n may load when it, or any stage after it, is empty, or the
    // output is taking a word: the whole tail then shifts forward by one.
    always_comb begin
        logic w_acc;
        w_acc   = out_ready;
        w_space = '0;
        for (int n = DEPTH - 1; n >= 0; n--) begin
            w_acc      = w_acc | ~r_valid[n];
            w_space[n] = w_acc;
        end
    end

    always_comb begin
        w_src_valid    = '0;
        w_src_data     = '0;
        w_src_mode     = '0;
        w_src_valid[0] = in_valid;
        w_src_data[0]  = w_perm;
        w_src_mode[0]  = in_mode;
        for (int n = 1; n < DEPTH; n++) begin
            w_src_valid[n] = r_valid[n-1];
            w_src_data[n]  = r_data[n-1];
            w_src_mode[n]  = r_mode[n-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            for (int n = 0; n < DEPTH; n++) begin
                if (w_space[n]) begin
                    r_valid[n] <= w_src_valid[n];
                end
            end
        end
    end

    // Payload registers are left unreset; they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        for (int n = 0; n < DEPTH; n++) begin
            if (w_space[n]) begin
                r_data[n] <= w_src_data[n];
                r_mode[n] <= w_src_mode[n];
            end
        end
    end

    // Handshakes are masked during reset so no word transfers while rst is high.
    assign in_ready  = w_space[0] & ~rst;
    assign out_valid = r_valid[DEPTH-1] & ~rst;
    assign out_data  = r_data[DEPTH-1];
    assign out_mode  = r_mode[DEPTH-1];

`ifdef BIT_PERMUTE_PIPE_COUNT_EN
    logic [31:0] r_xfer_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            r_xfer_count <= r_xfer_count + 32'd1;
        end
    end

    assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_bit_permute_pipe.sv
// tb/tb_bit_permute_pipe.sv - self-checking bench for bit_permute_pipe

module tb_bit_permute_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DUT A: WIDTH 8, DEPTH 2
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_in_mode, a_out_mode;
    logic [2:0] a_in_rot;
    // DUT B: WIDTH 2, DEPTH 1
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [1:0] b_in_data, b_out_data;
    logic [1:0] b_in_mode, b_out_mode;
    logic [0:0] b_in_rot;
    // DUT C: WIDTH 6, DEPTH 3
    logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [5:0] c_in_data, c_out_data;
    logic [1:0] c_in_mode, c_out_mode;
    logic [2:0] c_in_rot;
`ifdef BIT_PERMUTE_PIPE_COUNT_EN
    logic [31:0] a_xfer, b_xfer, c_xfer;
`endif

    bit_permute_pipe #(.WIDTH(8), .DEPTH(2)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_mode(a_in_mode), .in_rot(a_in_rot),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_mode(a_out_mode)
`ifdef BIT_PERMUTE_PIPE_COUNT_EN
        , .xfer_count(a_xfer)
`endif
    );

    bit_permute_pipe #(.WIDTH(2), .DEPTH(1)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_mode(b_in_mode), .in_rot(b_in_rot),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_mode(b_out_mode)
`ifdef BIT_PERMUTE_PIPE_COUNT_EN
        , .xfer_count(b_xfer)
`endif
    );

    bit_permute_pipe #(.WIDTH(6), .DEPTH(3)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .in_mode(c_in_mode), .in_rot(c_in_rot),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_mode(c_out_mode)
`ifdef BIT_PERMUTE_PIPE_COUNT_EN
        , .xfer_count(c_xfer)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference permutation: output bit position computed per input bit.
    function automatic logic [63:0] m_perm(input logic [63:0] d, input int mode,
                                           input int rot, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (mode)
                0: r[i] = d[i];
                1: r[i] = d[w-1-i];
                2: r[i] = ((w % 2 == 1) && (i == w - 1)) ? d[i] : d[i ^ 1];
                default: r[(i + rot) % w] = d[i];
            endcase
        end
        return r;
    endfunction

    typedef struct {
        logic [7:0] d;
        logic [1:0] m;
        int         t;
    } ent_t;

    ent_t        q[$];
    ent_t        e;
    logic        exp_ov, exp_ir;
    logic [63:0] p;
    int unsigned mcount = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model of DUT A: words in flight in order; the oldest reaches the
    // output exactly DEPTH cycles after its transfer, and the input side
    // has room whenever fewer than DEPTH words are held or the output drains.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mcount = 0;
        end else begin
            exp_ov = 1'b0;
            if (q.size() > 0) exp_ov = ((cyc - q[0].t) >= 2);
            exp_ir = a_out_ready || (q.size() < 2);
            chk("a_out_valid", a_out_valid, exp_ov);
            chk("a_in_ready", a_in_ready, exp_ir);
`ifdef BIT_PERMUTE_PIPE_COUNT_EN
            chk("a_xfer_count", a_xfer, mcount);
`endif
            if (exp_ov) begin
                chk("a_out_data", a_out_data, q[0].d);
                chk("a_out_mode", a_out_mode, q[0].m);
                if (a_out_ready) begin
                    q.delete(0);
                    mcount++;
                end
            end
            if (exp_ir && a_in_valid) begin
                p   = m_perm({56'd0, a_in_data}, int'(a_in_mode), int'(a_in_rot), 8);
                e.d = p[7:0];
                e.m = a_in_mode;
                e.t = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic drain();
        @(posedge clk); #1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [7:0] d, input logic [1:0] m, input logic [2:0] r,
                            input logic [7:0] ed, input string nm);
        drain();
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_data = d; a_in_mode = m; a_in_rot = r;
        @(negedge clk);
        chk({nm, "_in_ready"}, a_in_ready, 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_not_yet"}, a_out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_valid"}, a_out_valid, 1);
        chk({nm, "_data"}, a_out_data, ed);
        chk({nm, "_mode"}, a_out_mode, m);
    endtask

    task automatic test_b();
        logic [1:0] be [4];
        be = '{2'd0, 2'd2, 2'd1, 2'd3};
        b_in_mode   = 2'd2;
        b_out_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk); #1;
            b_in_valid = (k < 4);
            b_in_data  = 2'(k);
            @(negedge clk);
            if (k < 4) chk("b_in_ready", b_in_ready, 1);
            if (k == 0) begin
                chk("b_idle", b_out_valid, 0);
            end else begin
                chk("b_out_valid", b_out_valid, 1);
                chk("b_out_data", b_out_data, be[k-1]);
            end
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic test_c();
        logic [5:0] cd [2];
        logic [5:0] ce [2];
        cd = '{6'h03, 6'h21};
        ce = '{6'h06, 6'h03};
        c_in_mode   = 2'd3;
        c_in_rot    = 3'd7;
        c_out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            c_in_valid = 1'b1;
            c_in_data  = cd[k];
            @(posedge clk); #1;
            c_in_valid = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("c_out_valid", c_out_valid, 1);
            chk("c_rot_wrap", c_out_data, ce[k]);
        end
    endtask

    task automatic test_stall();
        int         acc;
        logic [7:0] held;
        drain();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_mode   = 2'd0;
        a_in_data   = 8'h10;
        acc  = 0;
        held = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (a_in_ready) acc++;
            if (k == 2) held = a_out_data;
            if (k == 4) begin
                chk("stall_in_ready", a_in_ready, 0);
                chk("stall_stable", a_out_data, held);
                chk("stall_head", a_out_data, 8'h10);
            end
            @(posedge clk); #1;
            a_in_data = a_in_data + 8'd1;
        end
        chk("stall_accepted", acc, 2);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("release_0", a_out_data, 8'h10);
        @(posedge clk);
        @(negedge clk);
        chk("release_1", a_out_data, 8'h11);
        @(posedge clk);
        @(negedge clk);
        chk("release_empty", a_out_valid, 0);
    endtask

    task automatic test_reset();
        drain();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_mode   = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        rst        = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
`ifdef BIT_PERMUTE_PIPE_COUNT_EN
        chk("rst_xfer_count", a_xfer, 0);
`endif
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a_in_data = 8'(k * 17);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("ten_drained", a_out_valid, 0);
`ifdef BIT_PERMUTE_PIPE_COUNT_EN
        chk("ten_xfer_count", a_xfer, 10);
`endif
    endtask

    initial begin
        a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_in_rot = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_in_rot = '0; b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_in_mode = '0; c_in_rot = '0; c_out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_a_out_valid", a_out_valid, 0);
        chk("reset_a_in_ready", a_in_ready, 1);

        chk("model_rev", m_perm(64'h01, 1, 0, 8), 64'h80);
        chk("model_rot", m_perm(64'hA1, 3, 3, 8), 64'h0D);
        chk("model_rot6", m_perm(64'h03, 3, 7, 6), 64'h06);
        chk("model_swap_odd", m_perm(64'h16, 2, 0, 5), 64'h19);

        test_b();
        test_c();
        send_one(8'h01, 2'd1, 3'd0, 8'h80, "rev");
        send_one(8'hA1, 2'd3, 3'd3, 8'h0D, "rot");
        send_one(8'h96, 2'd2, 3'd0, 8'h69, "swap");
        send_one(8'h5C, 2'd0, 3'd5, 8'h5C, "pass");
        test_stall();
        test_reset();

        for (int k = 0; k < 800; k++) begin
            @(posedge clk); #1;
            rst         = ($urandom_range(0, 99) == 0);
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_in_data   = 8'($urandom);
            a_in_mode   = 2'($urandom);
            a_in_rot    = 3'($urandom);
            a_out_ready = ($urandom_range(0, 9) < 6);
        end
        @(posedge clk); #1;
        rst        = 1'b0;
        a_in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/bit_permute_pipe.md
BIT_PERMUTE_PIPE -- requirements
Module: bit_permute_pipe

Interface
REQ-001 Parameter WIDTH, default 8, meaning data width in bits; legal range 2..64.
REQ-002 Parameter DEPTH, default 2, meaning number of pipeline register stages; legal range 1..8.
REQ-003 Port clk  input  1  meaning single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  meaning reset; reset is synchronous and active-high.
REQ-005 Port in_valid  input  1  meaning the upstream word is valid.
REQ-006 Port in_ready  output  1  meaning the block accepts a word this cycle.
REQ-007 Port in_data  input  WIDTH  meaning the word to permute.
REQ-008 Port in_mode  input  2  meaning permutation select, sampled with in_data.
REQ-009 Port in_rot  input  $clog2(WIDTH)  meaning rotate amount for mode 3, sampled with in_data.
REQ-010 Port out_valid  output  1  meaning out_data is valid.
REQ-011 Port out_ready  input  1  meaning the downstream consumer accepts the word.
REQ-012 Port out_data  output  WIDTH  meaning the permuted word.
REQ-013 Port out_mode  output  2  meaning the mode that produced out_data.

Function
REQ-014 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-015 Mode 0 SHALL pass the word through (out bit i = in bit i).
REQ-016 Mode 1 SHALL reverse the word (out bit i = in bit WIDTH-1-i).
REQ-017 Mode 2 SHALL swap adjacent pairs (out bit 2k = in bit 2k+1, out bit 2k+1 = in bit 2k); for odd WIDTH the MSB SHALL pass unchanged.
REQ-018 Mode 3 SHALL rotate left by in_rot modulo WIDTH; in_rot values >= WIDTH SHALL wrap modulo WIDTH.
REQ-019 The permutation SHALL be computed combinationally before stage 1 and SHALL be carried through DEPTH stages, each stage holding data, mode and a valid bit.
REQ-020 Stage n SHALL load from stage n-1 when stage n is empty or its content transfers out in the same cycle; otherwise stage n SHALL hold.
REQ-021 in_ready SHALL equal (stage 1 empty) OR (stage 1 advances this cycle); the ready path may be combinational from out_ready.
REQ-022 With out_ready held at 1, latency from input transfer to out_valid SHALL be exactly DEPTH cycles, and throughput SHALL be one word per cycle.
REQ-023 With out_ready=0 and all stages full, in_ready SHALL be 0 and no stored word SHALL be lost, duplicated or reordered.
REQ-024 When out_valid=1 and out_ready=0, out_data and out_mode SHALL remain stable until the transfer occurs.
REQ-025 Simultaneous input and output transfers on a full pipeline SHALL keep occupancy constant.

Reset
REQ-026 While rst=1 all stage valid bits SHALL clear on the next clock edge: out_valid=0 and in_ready=1 from the first cycle after rst is sampled high.
REQ-027 Stage data and mode registers need not be reset; out_data and out_mode are don't-care while out_valid=0.
REQ-028 rst asserted mid-stream SHALL discard all in-flight words; no transfer SHALL occur while rst=1.

Configuration
REQ-029 Macro BIT_PERMUTE_PIPE_COUNT_EN: when defined, the block SHALL add output port xfer_count (32 bits) counting output transfers, reset to 0 by rst and wrapping from 0xFFFFFFFF to 0; when undefined, the port and its counter SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-030 WIDTH=8, DEPTH=2, mode 1, in_data 0x01, out_ready=1 -> out_data 0x80 with out_mode 1, exactly 2 cycles after the input transfer.
REQ-031 WIDTH=2, DEPTH=1, mode 2, inputs 0,1,2,3 streamed -> outputs 0,2,1,3 in order, one per cycle.
REQ-032 WIDTH=8, mode 3, in_rot 3, in_data 0xA1 -> out_data 0x0D; WIDTH=6, in_rot 7 -> rotate by 1.
REQ-033 DEPTH=2, out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 words accepted, then in_ready=0 and out_data stable; releasing out_ready yields those words in order with none lost.
REQ-034 rst pulsed for 1 cycle with 2 words in flight -> out_valid=0 and in_ready=1 the next cycle; xfer_count=0 when BIT_PERMUTE_PIPE_COUNT_EN is defined.
REQ-035 BIT_PERMUTE_PIPE_COUNT_EN defined, 10 output transfers -> xfer_count=10; with the macro undefined the same bench SHALL produce identical out_data.
